smem_replay_controller: RTL and testbench
=========================================

// Module: smem_replay_controller
// PURPOSE
//  Holds one warp shared-memory request and drives per-lane bank IDs and pending bits to the bank-conflict arbiter.
//  Each cycle it issues the arbiter-granted lanes to the SRAM banks and replays the remaining lanes until all are served.
//  Collects read data per lane and returns one warp response.
//  Sits between the LSU request queue (upstream) and the arbiter/bank array (downstream).
// PARAMETERS
//  NUM_LANES  8   lanes per warp request
//  NUM_BANKS  8   SRAM banks, power of 2; BANK_W = $clog2(NUM_BANKS)
//  ADDR_W     12  byte address width; bank = addr[BANK_W+1:2], row = addr[ADDR_W-1:BANK_W+2]
//  DATA_W     32  word width
// PORTS
//  clk            in   1                    clock
//  rst_n          in   1                    async active-low reset
//  req_valid      in   1                    warp request valid
//  req_ready      out  1                    1 only in IDLE
//  req_we         in   1                    1=store, 0=load
//  req_lane_mask  in   NUM_LANES            active lanes
//  req_addr       in   NUM_LANES*ADDR_W     per-lane byte address
//  req_wdata      in   NUM_LANES*DATA_W     per-lane store data
//  arb_bank       out  NUM_LANES*BANK_W     registered bank ID per lane
//  arb_pending    out  NUM_LANES            lanes not yet served
//  arb_grant      in   NUM_LANES            lanes allowed to issue this cycle (combinational from arbiter)
//  bank_en        out  NUM_BANKS            bank access strobe
//  bank_we        out  1                    write strobe, common to all banks
//  bank_row       out  NUM_BANKS*(ADDR_W-BANK_W-2) row per bank
//  bank_wdata     out  NUM_BANKS*DATA_W     write data per bank
//  bank_rdata     in   NUM_BANKS*DATA_W     read data, valid 1 cycle after bank_en
//  resp_valid     out  1                    warp response valid
//  resp_ready     in   1                    consumer accepts response
//  resp_rdata     out  NUM_LANES*DATA_W     per-lane load data; inactive lanes read 0
//  replay_cnt     out  8                    issue cycles used by last request (saturates at 255)
// BEHAVIOUR
//  Reset (async): state=IDLE, pending=0, bank_en=0, bank_we=0, resp_valid=0, resp_rdata=0, replay_cnt=0.
//  FSM states: IDLE, ISSUE, DRAIN, RESP.
//  IDLE: on req_valid, latch request, set pending=req_lane_mask, go to ISSUE.
//    If the mask is 0, go directly to RESP; that response has replay_cnt=0.
//  ISSUE, every cycle:
//    - eff = arb_grant & pending.
//    - For each bank, the lowest eff lane targeting it drives bank_en/row/wdata.
//    - Other eff lanes on the same bank are not served and stay pending (defensive against arbiter bugs).
//    - Clear served lanes from pending; served_q <= served; replay_cnt++.
//    - If eff=0, stay in ISSUE; no timeout.
//  Leaving ISSUE, when pending becomes 0 after the current cycle:
//    - load: go to DRAIN;
//    - store: go to RESP.
//  Read capture: in any state, each lane set in served_q takes bank_rdata[its bank] into resp_rdata.
//  DRAIN: one cycle to capture the final read data, then go to RESP.
//  RESP: resp_valid=1, outputs held stable until resp_ready; then go to IDLE with resp_valid=0 next cycle.
//  Minimum latency (accept to resp_valid): 2 cycles for a conflict-free load, 1 extra cycle per replay.
//  Reset mid-operation aborts the request; no bank_en after rst_n is asserted.
// CONFIGURATION
//  SMEM_BROADCAST_EN defined:
//    - In a load, pending lanes whose full address equals a served lane's address complete in the same cycle.
//    - They copy that lane's data, so same-word lanes cost no replay.
//  Undefined: every lane needs its own grant; same-word lanes serialize like any bank conflict.
// TESTING
//  1. Load, 8 lanes, addr=4*i (distinct banks), all granted
//     -> one bank_en cycle of 0xFF; resp_valid 2 cycles after accept; replay_cnt=1.
//  2. Load, 8 lanes, all addr=0x40*i (bank 0), arbiter grants one lane per cycle
//     -> 8 issue cycles; resp_rdata[i]=mem[0x40*i]; replay_cnt=8.
//  3. Store, mask=0x05, grant held 0 for 3 cycles then 0x05
//     -> no bank_en during stall; one write cycle; resp_valid next cycle; replay_cnt=4.
//  4. mask=0 -> RESP the cycle after accept, no bank_en, replay_cnt=0.
//     resp_ready low 5 cycles -> outputs stable, req_ready=0.
//  5. rst_n low while in ISSUE with pending=0xF0
//     -> bank_en=0 and resp_valid=0 immediately; req_ready=1 after release.
//  6. SMEM_BROADCAST_EN, all 8 lanes addr=0x10, grant lane 0 only
//     -> done in 1 issue cycle, all lanes get mem[0x10].
//     Without the macro: 8 issue cycles.

Source files
------------

// File: rtl/smem_replay_controller.sv
// Shared-memory replay controller: holds one warp request, issues arbiter-granted lanes to the banks,
// replays the remainder and returns one warp response. Optional same-word broadcast: SMEM_BROADCAST_EN.
module smem_replay_controller #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               req_valid,
  output logic                                               req_ready,
  input  logic                                               req_we,
  input  logic [NUM_LANES-1:0]                               req_lane_mask,
  input  logic [NUM_LANES*ADDR_W-1:0]                        req_addr,
  input  logic [NUM_LANES*DATA_W-1:0]                        req_wdata,
  output logic [NUM_LANES*$clog2(NUM_BANKS)-1:0]             arb_bank,
  output logic [NUM_LANES-1:0]                               arb_pending,
  input  logic [NUM_LANES-1:0]                               arb_grant,
  output logic [NUM_BANKS-1:0]                               bank_en,
  output logic                                               bank_we,
  output logic [NUM_BANKS*(ADDR_W-$clog2(NUM_BANKS)-2)-1:0]  bank_row,
  output logic [NUM_BANKS*DATA_W-1:0]                        bank_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0]                        bank_rdata,
  output logic                                               resp_valid,
  input  logic                                               resp_ready,
  output logic [NUM_LANES*DATA_W-1:0]                        resp_rdata,
  output logic [7:0]                                         replay_cnt
);

  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned ROW_W  = ADDR_W - BANK_W - 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t state_q, state_d;

  logic                 we_q;
  logic [NUM_LANES-1:0] pending_q;
  logic [NUM_LANES-1:0] served_q;
  logic [NUM_LANES-1:0] served;
  logic [NUM_LANES-1:0] done;
  logic [CNT_W-1:0]     cnt_q;
  logic [ADDR_W-1:0]    addr_q  [NUM_LANES];
  logic [DATA_W-1:0]    wdata_q [NUM_LANES];
  logic [BANK_W-1:0]    lane_bank [NUM_LANES];
  logic [ROW_W-1:0]     lane_row  [NUM_LANES];

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_bank[l] = addr_q[l][BANK_W+1:2];
      lane_row[l]  = addr_q[l][ADDR_W-1:BANK_W+2];
      arb_bank[l*BANK_W +: BANK_W] = lane_bank[l];
    end
  end

`ifndef SMEM_BROADCAST_EN
  logic [2*NUM_LANES-1:0] unused_byte_offset;
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      unused_byte_offset[2*l +: 2] = addr_q[l][1:0];
    end
  end
`endif

  assign arb_pending = pending_q;
  assign replay_cnt  = cnt_q;

  // Bank issue: lowest granted pending lane wins each bank; losers stay pending.
  always_comb begin
    bank_en    = '0;
    bank_we    = 1'b0;
    bank_row   = '0;
    bank_wdata = '0;
    served     = '0;
    done       = '0;
    if (state_q == ISSUE) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (pending_q[l] && arb_grant[l] && !bank_en[lane_bank[l]]) begin
          served[l]                                = 1'b1;
          bank_en[lane_bank[l]]                    = 1'b1;
          bank_row[lane_bank[l]*ROW_W +: ROW_W]    = lane_row[l];
          bank_wdata[lane_bank[l]*DATA_W +: DATA_W] = wdata_q[l];
        end
      end
      bank_we = we_q && (served != '0);
    end
    done = served;
`ifdef SMEM_BROADCAST_EN
    // Same-word lanes share the winner's bank, so capturing their own bank's data is the copy.
    if (state_q == ISSUE && !we_q) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (pending_q[j] && served[i] && addr_q[i] == addr_q[j]) begin
            done[j] = 1'b1;
          end
        end
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid) state_d = (req_lane_mask == '0) ? RESP : ISSUE;
      ISSUE: if ((pending_q & ~done) == '0) state_d = we_q ? RESP : DRAIN;
      DRAIN: state_d = RESP;
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_ready  <= (state_d == IDLE);
      resp_valid <= (state_d == RESP);
    end
  end

  // Request latch, pending bookkeeping and read capture; stores never touch resp_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      pending_q  <= '0;
      served_q   <= '0;
      cnt_q      <= '0;
      resp_rdata <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        addr_q[l]  <= '0;
        wdata_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (served_q[l] && !we_q) begin
          resp_rdata[l*DATA_W +: DATA_W] <= bank_rdata[lane_bank[l]*DATA_W +: DATA_W];
        end
      end
      served_q <= done;
      if (state_q == ISSUE) begin
        pending_q <= pending_q & ~done;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == IDLE && req_valid) begin
        we_q       <= req_we;
        pending_q  <= req_lane_mask;
        cnt_q      <= '0;
        resp_rdata <= '0;
        for (int l = 0; l < NUM_LANES; l++) begin
          addr_q[l]  <= req_addr[l*ADDR_W +: ADDR_W];
          wdata_q[l] <= req_wdata[l*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_smem_replay_controller.sv
// Directed bench for smem_replay_controller with a behavioural bank array and a mode-switched arbiter.
module tb_smem_replay_controller;

  localparam int NL = 8;
  localparam int NB = 8;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 3;
  localparam int RW = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [NL-1:0]    req_lane_mask = '0;
  logic [NL*AW-1:0] req_addr = '0;
  logic [NL*DW-1:0] req_wdata = '0;
  logic [NL*BW-1:0] arb_bank;
  logic [NL-1:0]    arb_pending;
  logic [NL-1:0]    arb_grant;
  logic [NB-1:0]    bank_en;
  logic             bank_we;
  logic [NB*RW-1:0] bank_row;
  logic [NB*DW-1:0] bank_wdata;
  logic [NB*DW-1:0] bank_rdata;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [NL*DW-1:0] resp_rdata;
  logic [7:0]       replay_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int en_cycles = 0;
  int we_cycles = 0;
  logic [NB-1:0] last_en = '0;
  int acc_cyc = 0;
  int en0 = 0;
  int we0 = 0;

  logic          grant_lowest = 1'b0;
  logic [NL-1:0] grant_val = '0;

  logic [DW-1:0] wr_mem [NB][128];
  logic          wr_ok  [NB][128];
  logic [DW-1:0] rd_r   [NB];

  always #5 clk = ~clk;

  smem_replay_controller dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lane_mask(req_lane_mask), .req_addr(req_addr), .req_wdata(req_wdata),
    .arb_bank(arb_bank), .arb_pending(arb_pending), .arb_grant(arb_grant),
    .bank_en(bank_en), .bank_we(bank_we), .bank_row(bank_row), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .replay_cnt(replay_cnt)
  );

  function automatic logic [DW-1:0] init_word(input int b, input int r);
    return 32'hA000_0000 | 32'((r << 5) | (b << 2));
  endfunction

  always_comb begin
    if (grant_lowest) arb_grant = arb_pending & (~arb_pending + 8'd1);
    else              arb_grant = grant_val;
  end

  always_comb begin
    for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = rd_r[b];
  end

  // Bank array: one-cycle read latency, unwritten words return init_word
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      for (int b = 0; b < NB; b++)
        for (int r = 0; r < 128; r++) wr_ok[b][r] <= 1'b0;
    end
    for (int b = 0; b < NB; b++) begin
      if (bank_en[b]) begin
        if (bank_we) begin
          wr_mem[b][bank_row[b*RW +: RW]] <= bank_wdata[b*DW +: DW];
          wr_ok[b][bank_row[b*RW +: RW]]  <= 1'b1;
        end else begin
          rd_r[b] <= wr_ok[b][bank_row[b*RW +: RW]] ? wr_mem[b][bank_row[b*RW +: RW]]
                                                    : init_word(b, int'(bank_row[b*RW +: RW]));
        end
      end
    end
    if (bank_en != '0) begin
      en_cycles <= en_cycles + 1;
      last_en   <= bank_en;
      if (bank_we) we_cycles <= we_cycles + 1;
    end
  end

  task automatic send_req(input logic we, input logic [NL-1:0] mask,
                          input logic [NL*AW-1:0] addr, input logic [NL*DW-1:0] wd);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_we = we; req_lane_mask = mask; req_addr = addr; req_wdata = wd;
    en0 = en_cycles; we0 = we_cycles;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    int n = 0;
    while (resp_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    lat = (resp_valid === 1'b1) ? cyc - acc_cyc : -1;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bank_en !== 8'h00) begin miscompares++; $display("FAIL reset_bank_en: got %h want 00", bank_en); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    vectors++; if (arb_pending !== 8'h00) begin miscompares++; $display("FAIL reset_pending: got %h want 00", arb_pending); end
    vectors++; if (replay_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_replay_cnt: got %0d want 0", replay_cnt); end
    vectors++; if (resp_rdata !== '0) begin miscompares++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_conflict_free();
    logic [NL*AW-1:0] a;
    logic [NL*DW-1:0] exp;
    int lat;
    for (int i = 0; i < NL; i++) begin
      a[i*AW +: AW] = 12'(4 * i);
      exp[i*DW +: DW] = 32'hA000_0000 + 32'(4 * i);
    end
    grant_lowest = 1'b0; grant_val = 8'hFF;
    send_req(1'b0, 8'hFF, a, '0);
    vectors++; if (arb_pending !== 8'hFF) begin miscompares++; $display("FAIL cf_pending: got %h want ff", arb_pending); end
    vectors++; if (arb_bank !== 24'hFAC688) begin miscompares++; $display("FAIL cf_arb_bank: got %h want fac688", arb_bank); end
    wait_resp(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL cf_latency: got %0d want 2", lat); end
    vectors++; if (en_cycles - en0 != 1) begin miscompares++; $display("FAIL cf_en_cycles: got %0d want 1", en_cycles - en0); end
    vectors++; if (last_en !== 8'hFF) begin miscompares++; $display("FAIL cf_bank_en: got %h want ff", last_en); end
    vectors++; if (replay_cnt !== 8'd1) begin miscompares++; $display("FAIL cf_replay_cnt: got %0d want 1", replay_cnt); end
    vectors++; if (resp_rdata !== exp) begin miscompares++; $display("FAIL cf_rdata: got %h want %h", resp_rdata, exp); end
    finish_resp();
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL cf_resp_drop: got %b want 0", resp_valid); end
  endtask

  task automatic test_bank_conflict();
    logic [NL*AW-1:0] a;
    logic [NL*DW-1:0] exp;
    int lat;
    for (int i = 0; i < NL; i++) begin
      a[i*AW +: AW] = 12'(64 * i);
      exp[i*DW +: DW] = 32'hA000_0000 + 32'(64 * i);
    end
    grant_lowest = 1'b1;
    send_req(1'b0, 8'hFF, a, '0);
    wait_resp(lat);
    grant_lowest = 1'b0;
    vectors++; if (lat != 9) begin miscompares++; $display("FAIL bc_latency: got %0d want 9", lat); end
    vectors++; if (en_cycles - en0 != 8) begin miscompares++; $display("FAIL bc_en_cycles: got %0d want 8", en_cycles - en0); end
    vectors++; if (last_en !== 8'h01) begin miscompares++; $display("FAIL bc_bank_en: got %h want 01", last_en); end
    vectors++; if (replay_cnt !== 8'd8) begin miscompares++; $display("FAIL bc_replay_cnt: got %0d want 8", replay_cnt); end
    vectors++; if (resp_rdata !== exp) begin miscompares++; $display("FAIL bc_rdata: got %h want %h", resp_rdata, exp); end
    finish_resp();
  endtask

  task automatic test_store_stall();
    logic [NL*AW-1:0] a = '0;
    logic [NL*DW-1:0] d = '0;
    int lat;
    a[0*AW +: AW] = 12'h100; d[0*DW +: DW] = 32'hDEAD_BEEF;
    a[2*AW +: AW] = 12'h0A8; d[2*DW +: DW] = 32'h1234_5678;
    grant_lowest = 1'b0; grant_val = 8'h00;
    send_req(1'b1, 8'h05, a, d);
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (en_cycles != en0) begin miscompares++; $display("FAIL st_stall_en: got %0d want 0", en_cycles - en0); end
    vectors++; if (arb_pending !== 8'h05) begin miscompares++; $display("FAIL st_stall_pending: got %h want 05", arb_pending); end
    grant_val = 8'h05;
    wait_resp(lat);
    grant_val = 8'h00;
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL st_latency: got %0d want 4", lat); end
    vectors++; if (we_cycles - we0 != 1) begin miscompares++; $display("FAIL st_we_cycles: got %0d want 1", we_cycles - we0); end
    vectors++; if (last_en !== 8'h05) begin miscompares++; $display("FAIL st_bank_en: got %h want 05", last_en); end
    vectors++; if (replay_cnt !== 8'd4) begin miscompares++; $display("FAIL st_replay_cnt: got %0d want 4", replay_cnt); end
    vectors++; if (wr_mem[0][8] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL st_mem_b0: got %h want deadbeef", wr_mem[0][8]); end
    vectors++; if (wr_mem[2][5] !== 32'h1234_5678) begin miscompares++; $display("FAIL st_mem_b2: got %h want 12345678", wr_mem[2][5]); end
    finish_resp();
  endtask

  task automatic test_empty_mask();
    int lat;
    grant_lowest = 1'b0; grant_val = 8'hFF;
    send_req(1'b0, 8'h00, '0, '0);
    wait_resp(lat);
    vectors++; if (lat != 0) begin miscompares++; $display("FAIL em_latency: got %0d want 0", lat); end
    vectors++; if (replay_cnt !== 8'd0) begin miscompares++; $display("FAIL em_replay_cnt: got %0d want 0", replay_cnt); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL em_hold_valid[%0d]: got %b want 1", c, resp_valid); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL em_hold_ready[%0d]: got %b want 0", c, req_ready); end
      vectors++; if (resp_rdata !== '0) begin miscompares++; $display("FAIL em_hold_rdata[%0d]: got %h want 0", c, resp_rdata); end
    end
    vectors++; if (en_cycles != en0) begin miscompares++; $display("FAIL em_en_cycles: got %0d want 0", en_cycles - en0); end
    finish_resp();
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL em_resp_drop: got %b want 0", resp_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL em_req_ready: got %b want 1", req_ready); end
    grant_val = 8'h00;
  endtask

  task automatic test_reset_mid();
    logic [NL*AW-1:0] a;
    for (int i = 0; i < NL; i++) a[i*AW +: AW] = 12'(4 * i);
    grant_lowest = 1'b0; grant_val = 8'h0F;
    send_req(1'b0, 8'hFF, a, '0);
    @(posedge clk); #1;
    grant_val = 8'hF0;
    #1;
    vectors++; if (arb_pending !== 8'hF0) begin miscompares++; $display("FAIL rm_pending: got %h want f0", arb_pending); end
    vectors++; if (bank_en !== 8'hF0) begin miscompares++; $display("FAIL rm_bank_en_pre: got %h want f0", bank_en); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bank_en !== 8'h00) begin miscompares++; $display("FAIL rm_bank_en: got %h want 00", bank_en); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rm_resp_valid: got %b want 0", resp_valid); end
    vectors++; if (arb_pending !== 8'h00) begin miscompares++; $display("FAIL rm_pending_clr: got %h want 00", arb_pending); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rm_req_ready: got %b want 1", req_ready); end
    vectors++; if (replay_cnt !== 8'd0) begin miscompares++; $display("FAIL rm_replay_cnt: got %0d want 0", replay_cnt); end
    vectors++; if (bank_en !== 8'h00) begin miscompares++; $display("FAIL rm_bank_en_post: got %h want 00", bank_en); end
    grant_val = 8'h00;
  endtask

  task automatic test_back_to_back();
    logic [NL*AW-1:0] a = '0;
    logic [NL*DW-1:0] exp = '0;
    int lat;
    a[0*AW +: AW] = 12'h7FC; exp[0*DW +: DW] = 32'hA000_07FC;
    a[7*AW +: AW] = 12'h004; exp[7*DW +: DW] = 32'hA000_0004;
    grant_lowest = 1'b0; grant_val = 8'hFF;
    send_req(1'b0, 8'h81, a, '0);
    wait_resp(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL bb1_latency: got %0d want 2", lat); end
    vectors++; if (last_en !== 8'h82) begin miscompares++; $display("FAIL bb1_bank_en: got %h want 82", last_en); end
    vectors++; if (resp_rdata !== exp) begin miscompares++; $display("FAIL bb1_rdata: got %h want %h", resp_rdata, exp); end
    finish_resp();
    a = '0; exp = '0;
    a[1*AW +: AW] = 12'h008; exp[1*DW +: DW] = 32'hA000_0008;
    send_req(1'b0, 8'h02, a, '0);
    wait_resp(lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL bb2_latency: got %0d want 2", lat); end
    vectors++; if (replay_cnt !== 8'd1) begin miscompares++; $display("FAIL bb2_replay_cnt: got %0d want 1", replay_cnt); end
    vectors++; if (resp_rdata !== exp) begin miscompares++; $display("FAIL bb2_rdata: got %h want %h", resp_rdata, exp); end
    finish_resp();
    grant_val = 8'h00;
  endtask

  task automatic test_broadcast();
    logic [NL*AW-1:0] a;
    logic [NL*DW-1:0] exp;
    int lat;
    int exp_lat;
    int exp_cnt;
`ifdef SMEM_BROADCAST_EN
    exp_lat = 2; exp_cnt = 1;
`else
    exp_lat = 9; exp_cnt = 8;
`endif
    for (int i = 0; i < NL; i++) begin
      a[i*AW +: AW] = 12'h010;
      exp[i*DW +: DW] = 32'hA000_0010;
    end
    grant_lowest = 1'b1;
    send_req(1'b0, 8'hFF, a, '0);
    wait_resp(lat);
    grant_lowest = 1'b0;
    vectors++; if (lat != exp_lat) begin miscompares++; $display("FAIL bcast_latency: got %0d want %0d", lat, exp_lat); end
    vectors++; if (replay_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL bcast_replay_cnt: got %0d want %0d", replay_cnt, exp_cnt); end
    vectors++; if (en_cycles - en0 != exp_cnt) begin miscompares++; $display("FAIL bcast_en_cycles: got %0d want %0d", en_cycles - en0, exp_cnt); end
    vectors++; if (last_en !== 8'h10) begin miscompares++; $display("FAIL bcast_bank_en: got %h want 10", last_en); end
    vectors++; if (resp_rdata !== exp) begin miscompares++; $display("FAIL bcast_rdata: got %h want %h", resp_rdata, exp); end
    finish_resp();
  endtask

  initial begin
    test_reset();
    test_conflict_free();
    test_bank_conflict();
    test_store_stall();
    test_empty_mask();
    test_reset_mid();
    test_back_to_back();
    test_broadcast();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
